// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised rx, start-glitch rejection,
// optional parity, one or two stop bits, framing/parity/break reporting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HB_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t state_q, state_d;
    logic rx_meta_q, rxs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic par_q, par_d, perr_q, perr_d;
    logic tick, last_stop;
    logic sample_data, sample_par, sample_stop, done;

    // START waits half a bit; every later state waits a full bit
    assign tick = (state_q == START) ? (cnt_q == HB_M1)
                                     : (cnt_q == BIT_M1);
    assign last_stop = (STOP_BITS == 2) ? stop_q : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (!rxs_q) state_d = START;
            START:  if (tick) state_d = rxs_q ? IDLE : DATA;
            DATA: begin
                if (tick && bit_q == LAST_BIT)
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (tick) state_d = STOP;
            STOP: begin
                if (tick) begin
                    if (!rxs_q)         state_d = WAIT_IDLE;
                    else if (last_stop) state_d = IDLE;
                end
            end
            WAIT_IDLE: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        sample_data = (state_q == DATA) && tick;
        sample_par  = (state_q == PARITY) && tick;
        sample_stop = (state_q == STOP) && tick;
        done        = sample_stop && (!rxs_q || last_stop);
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        perr_d  = perr_q;
        if (state_q == IDLE || state_q == WAIT_IDLE || tick)
            cnt_d = '0;
        if (state_q == IDLE) begin
            bit_d  = '0;
            stop_d = 1'b0;
        end
        if (sample_data) begin
            bit_d   = bit_q + 4'd1;
            shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
        end
        if (sample_stop) stop_d = 1'b1;
        if (sample_par) begin
            par_d  = rxs_q;
            perr_d = rxs_q ^ (^shift_q) ^ PAR_ODD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            data_valid <= done;
            if (done) begin
                data_out   <= shift_q;
                parity_err <= (PARITY_EN != 0) && perr_q;
                frame_err  <= !rxs_q;
                break_det  <= !rxs_q && (shift_q == '0)
                              && ((PARITY_EN == 0) || !par_q);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 5N2 instances
// driven with hand-built frames, glitches, breaks and mid-frame reset.
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

    logic [7:0] dout0, dout1;
    logic [4:0] dout2;
    logic dval0, perr0, ferr0, brk0, busy0;
    logic dval1, perr1, ferr1, brk1, busy1;
    logic dval2, perr2, ferr2, brk2, busy2;

    uart_rx_param u_def (
        .clk(clk), .rst(rst), .rx(rx0),
        .data_out(dout0), .data_valid(dval0),
        .parity_err(perr0), .frame_err(ferr0),
        .break_det(brk0), .busy(busy0)
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst(rst), .rx(rx1),
        .data_out(dout1), .data_valid(dval1),
        .parity_err(perr1), .frame_err(ferr1),
        .break_det(brk1), .busy(busy1)
    );

    uart_rx_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(5), .STOP_BITS(2)
    ) u_d5 (
        .clk(clk), .rst(rst), .rx(rx2),
        .data_out(dout2), .data_valid(dval2),
        .parity_err(perr2), .frame_err(ferr2),
        .break_det(brk2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    int n0 = 0, n1 = 0, n2 = 0;
    int t_dv0 = 0;
    logic [7:0] m_d0 = '0, m_d1 = '0;
    logic [4:0] m_d2 = '0;
    logic m_pe0 = 0, m_fe0 = 0, m_bd0 = 0;
    logic m_pe1 = 0, m_fe1 = 0, m_bd1 = 0;
    logic m_e2 = 0;

    always @(negedge clk) begin
        if (dval0) begin
            n0++;
            t_dv0 = cyc;
            m_d0 = dout0;
            m_pe0 = perr0;
            m_fe0 = ferr0;
            m_bd0 = brk0;
        end
        if (dval1) begin
            n1++;
            m_d1 = dout1;
            m_pe1 = perr1;
            m_fe1 = ferr1;
            m_bd1 = brk1;
        end
        if (dval2) begin
            n2++;
            m_d2 = dout2;
            m_e2 = m_e2 | perr2 | ferr2 | brk2;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int sel, input logic v, input int n);
        case (sel)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int sel, input int cpb, input int nb,
                        input logic [8:0] d, input bit pen,
                        input logic pb, input int ns,
                        input logic sv);
        drv(sel, 1'b0, cpb);
        for (int i = 0; i < nb; i++) drv(sel, d[i], cpb);
        if (pen) drv(sel, pb, cpb);
        for (int i = 0; i < ns; i++) drv(sel, sv, cpb);
    endtask

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int t0;
        int lat;
        logic [7:0] pat;

        repeat (3) @(negedge clk);
        check("rst_dout", dout0, 0);
        check("rst_dval", dval0, 0);
        check("rst_flags", {perr0, ferr0, brk0}, 0);
        check("rst_busy", busy0, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        t0 = cyc;
        send(0, 10, 8, 9'h0AA, 0, 0, 1, 1);
        drv(0, 1'b1, 30);
        lat = t_dv0 - t0;
        check("aa_count", n0, 1);
        check("aa_data", m_d0, 8'hAA);
        check("aa_flags", {m_pe0, m_fe0, m_bd0}, 0);
        check("aa_latency", (lat >= 96 && lat <= 98), 1);
        check("aa_busy_idle", busy0, 0);
        send(0, 10, 8, 9'h055, 0, 0, 1, 1);
        drv(0, 1'b1, 30);
        check("55_count", n0, 2);
        check("55_data", m_d0, 8'h55);
        check("55_flags", {m_pe0, m_fe0, m_bd0}, 0);

        send(1, 10, 8, 9'h007, 1, 1'b1, 1, 1);
        drv(1, 1'b1, 30);
        check("par_ok_count", n1, 1);
        check("par_ok_data", m_d1, 8'h07);
        check("par_ok_perr", m_pe1, 0);
        send(1, 10, 8, 9'h007, 1, 1'b0, 1, 1);
        drv(1, 1'b1, 30);
        check("par_bad_count", n1, 2);
        check("par_bad_data", m_d1, 8'h07);
        check("par_bad_perr", m_pe1, 1);
        check("par_bad_fe", {m_fe1, m_bd1}, 0);

        base = n0;
        send(0, 10, 8, 9'h03C, 0, 0, 1, 1'b0);
        drv(0, 1'b0, 50);
        check("fe_count", n0 - base, 1);
        check("fe_data", m_d0, 8'h3C);
        check("fe_flag", m_fe0, 1);
        check("fe_nobrk", m_bd0, 0);
        check("fe_busy_low", busy0, 1);
        drv(0, 1'b1, 30);
        check("fe_count_after", n0 - base, 1);
        check("fe_busy_idle", busy0, 0);

        base = n0;
        drv(0, 1'b0, 120);
        check("brk_count", n0 - base, 1);
        check("brk_data", m_d0, 0);
        check("brk_fe", m_fe0, 1);
        check("brk_det", m_bd0, 1);
        drv(0, 1'b1, 20);
        send(0, 10, 8, 9'h0A5, 0, 0, 1, 1);
        drv(0, 1'b1, 30);
        check("a5_count", n0 - base, 2);
        check("a5_data", m_d0, 8'hA5);
        check("a5_flags", {m_pe0, m_fe0, m_bd0}, 0);

        base = n0;
        drv(0, 1'b0, 3);
        drv(0, 1'b1, 8);
        check("glitch_busy", busy0, 0);
        drv(0, 1'b1, 20);
        check("glitch_count", n0 - base, 0);

        base = n0;
        pat = 8'h81;
        drv(0, 1'b0, 10);
        for (int i = 0; i < 4; i++) drv(0, pat[i], 10);
        drv(0, pat[4], 5);
        check("mid_busy_pre", busy0, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_dout", dout0, 0);
        check("mid_rst_dval", dval0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_flags", {perr0, ferr0, brk0}, 0);
        rx0 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        drv(0, 1'b1, 20);
        check("mid_no_frame", n0 - base, 0);
        send(0, 10, 8, 9'h081, 0, 0, 1, 1);
        drv(0, 1'b1, 30);
        check("81_count", n0 - base, 1);
        check("81_data", m_d0, 8'h81);
        check("81_flags", {m_pe0, m_fe0, m_bd0}, 0);

        for (int k = 0; k < 3; k++)
            send(2, 16, 5, 9'h013, 0, 0, 2, 1);
        drv(2, 1'b1, 40);
        check("d5_count", n2, 3);
        check("d5_data", m_d2, 5'h13);
        check("d5_errs", m_e2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver that extends the basic fixed 8N1 receiver. It adds configurable bit period, data width, optional parity, one or two stop bits, and an input synchroniser. It also rejects start-bit glitches and reports framing, parity and break errors. It sits at the serial-input boundary and feeds received words to downstream logic, paired with the team's UART transmitter.

Parameters:
CLKS_PER_BIT, 10, clk cycles per serial bit; legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous active-low reset; 0 = reset asserted.
rx  input  1  serial line, idle high, asynchronous to clk.
data_out  output  DATA_BITS  last received word; holds until the next frame completes.
data_valid  output  1  one-cycle pulse; data_out, parity_err, frame_err and break_det are valid while it is high.
parity_err  output  1  received parity mismatched; always 0 when PARITY_EN=0.
frame_err  output  1  at least one stop bit was sampled low.
break_det  output  1  all data bits, parity (if enabled) and stop bits were sampled 0.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, counters clear, data_out=0, data_valid=0, parity_err=0, frame_err=0, break_det=0, busy=0. Synchroniser flops reset to 1 (line idle).
- rx passes through a 2-flop synchroniser; all logic below uses the synchronised value rxs.
- Half-bit point HB = CLKS_PER_BIT/2, rounded down.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rxs=0, clear the bit counter and go to START.
- START: count HB cycles.
  - If rxs=1 at the half-bit sample: glitch; return to IDLE, no output.
  - Otherwise go to DATA with the cycle counter cleared.
- DATA: sample rxs every CLKS_PER_BIT cycles, i.e. at each bit centre. Shift LSB first into the shift register.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: sample one bit.
  - Expected parity = XOR of the data bits, inverted when PARITY_ODD=1.
  - parity_err_int = (sample != expected).
- STOP: sample STOP_BITS bits.
  - Any sample of 0 sets frame_err_int.
  - The first low stop sample ends the frame immediately; the second stop bit is not sampled.
- End of frame:
  - On the clk edge after the final stop sample, data_out loads the shift register, error flags load, and data_valid=1 for exactly one cycle.
  - Total latency from the start-bit falling edge at rx to data_valid is about 2 + HB + (DATA_BITS + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles, within ±1 cycle.
- After end of frame:
  - If frame_err=1, go to WAIT_IDLE; it stays there until rxs=1, then goes to IDLE. A held-low line therefore produces exactly one break/frame report.
  - Otherwise go directly to IDLE. A start bit immediately following the stop-bit centre is accepted.
- break_det=1 only when frame_err=1 and the shift register is 0, and the parity sample is also 0 when parity is enabled.
- Error flags are held with data_out until the next data_valid. They are meaningful only while data_valid=1.
- Reset mid-frame abandons the frame; no data_valid is produced for it.
- The bit counter must be wide enough for DATA_BITS=9.
- The cycle counter width is $clog2(CLKS_PER_BIT)+1.

Test Plan:
- Default parameters (clk 10 ns, bit period 100 ns); send 8'hAA then 8'h55 in 8N1 frames → one data_valid each, data_out=8'hAA then 8'h55, all error flags 0, busy low between frames.
- PARITY_EN=1, PARITY_ODD=0; send 8'h07 with parity bit 1, then 8'h07 with parity bit 0 → first frame parity_err=0, second parity_err=1, data_out=8'h07 both times.
- Send 8'h3C with the stop bit driven 0, then hold rx low for 5 bit times → exactly one data_valid with frame_err=1 and break_det=0; no further output until rx returns high.
- Hold rx=0 for 12 bit times → one data_valid with data_out=0, frame_err=1, break_det=1; then 8'hA5 sent after rx returns high is received correctly.
- Drive a 3-cycle low glitch on rx while idle → no data_valid, busy returns to 0 within HB+3 cycles. Assert rst=0 mid-frame at data bit 4 → all outputs 0 immediately; the next clean 8'h81 frame is received correctly.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=16; send 5'h13 back-to-back 3 times → three data_valid pulses, data_out=5'h13, no errors.
